// File: rtl/npu_pkg.sv
// Shared types for the NPU sequencer: FSM states, operation kinds, element sizing.
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WR,
    DONE
  } npu_state_e;

  typedef enum logic {
    OP_MM,
    OP_CONV
  } npu_op_e;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ELEM_BYTES = DATA_W_DEF / 8;

endpackage

// File: rtl/npu_mac.sv
// Sequential multiply-accumulate: latches the A operand, then folds A*B into acc as B arrives.
module npu_mac #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture_a,
  input  logic              capture_b_acc,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] a_q;

  // Product is truncated to DATA_W; signed and unsigned operands wrap identically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      acc <= '0;
    end else begin
      if (capture_a) begin
        a_q <= rd_data;
      end
      if (clear) begin
        acc <= '0;
      end else if (capture_b_acc) begin
        acc <= acc + a_q * rd_data;
      end
    end
  end

endmodule

// File: rtl/npu_seq_engine.sv
// NPU sequencer: runs an NxN matrix multiply or 1-D valid convolution over one shared
// memory port with a single MAC, signalling completion with a one-cycle done pulse.
module npu_seq_engine
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned N      = 4,
  parameter int unsigned K      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_mm,
  input  logic              start_conv,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned STRIDE = DATA_W / 8;

  npu_state_e        state_q, state_nxt;
  npu_op_e           op_q, op_nxt;
  logic [IDX_W-1:0]  i_q, j_q, k_q;
  logic [IDX_W-1:0]  i_nxt, j_nxt, k_nxt;
  logic [IDX_W-1:0]  last_k;
  logic              last_out;
  logic [ADDR_W-1:0] ba_q, bb_q, bc_q;
  logic [ADDR_W-1:0] ba_nxt, bb_nxt, bc_nxt;
  logic [ADDR_W-1:0] i_a, j_a, k_a;
  logic [ADDR_W-1:0] addr_nxt;
  logic              clear_c, cap_a_c, mac_c;

  assign last_k   = (op_q == OP_MM) ? IDX_W'(N - 1) : IDX_W'(K - 1);
  assign last_out = (op_q == OP_MM) ? ((i_q == IDX_W'(N - 1)) && (j_q == IDX_W'(N - 1)))
                                    : (i_q == IDX_W'(N - K));

  // Next-state, index stepping and MAC control.
  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    k_nxt     = k_q;
    ba_nxt    = ba_q;
    bb_nxt    = bb_q;
    bc_nxt    = bc_q;
    clear_c   = 1'b0;
    cap_a_c   = 1'b0;
    mac_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mm || start_conv) begin
          state_nxt = RD_A;
          op_nxt    = start_mm ? OP_MM : OP_CONV;
          ba_nxt    = base_a;
          bb_nxt    = base_b;
          bc_nxt    = base_c;
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
          clear_c   = 1'b1;
        end
      end
      RD_A: state_nxt = RD_B;
      RD_B: begin
        state_nxt = MAC;
        cap_a_c   = 1'b1;
      end
      MAC: begin
        mac_c = 1'b1;
        if (k_q == last_k) begin
          state_nxt = WR;
        end else begin
          k_nxt     = k_q + IDX_W'(1);
          state_nxt = RD_A;
        end
      end
      WR: begin
        clear_c = 1'b1;
        k_nxt   = '0;
        if (last_out) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD_A;
          if (op_q == OP_CONV) begin
            i_nxt = i_q + IDX_W'(1);
          end else if (j_q == IDX_W'(N - 1)) begin
            j_nxt = '0;
            i_nxt = i_q + IDX_W'(1);
          end else begin
            j_nxt = j_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_a = ADDR_W'(i_nxt);
  assign j_a = ADDR_W'(j_nxt);
  assign k_a = ADDR_W'(k_nxt);

  // Address for the upcoming state so the port outputs can be registered in step with it.
  always_comb begin
    addr_nxt = '0;
    case (state_nxt)
      RD_A: addr_nxt = ba_nxt + ADDR_W'(STRIDE) *
                       ((op_nxt == OP_MM) ? (i_a * ADDR_W'(N) + k_a) : (i_a + k_a));
      RD_B: addr_nxt = bb_nxt + ADDR_W'(STRIDE) *
                       ((op_nxt == OP_MM) ? (k_a * ADDR_W'(N) + j_a) : k_a);
      WR:   addr_nxt = bc_nxt + ADDR_W'(STRIDE) *
                       ((op_nxt == OP_MM) ? (i_a * ADDR_W'(N) + j_a) : i_a);
      default: addr_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MM;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      i_q     <= i_nxt;
      j_q     <= j_nxt;
      k_q     <= k_nxt;
      ba_q    <= ba_nxt;
      bb_q    <= bb_nxt;
      bc_q    <= bc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      busy      <= state_nxt inside {RD_A, RD_B, MAC, WR};
      done      <= (state_nxt == DONE);
      mem_rd_en <= (state_nxt == RD_A) || (state_nxt == RD_B);
      mem_wr_en <= (state_nxt == WR);
      mem_addr  <= addr_nxt;
    end
  end

  npu_mac #(
    .DATA_W(DATA_W)
  ) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear_c),
    .capture_a    (cap_a_c),
    .capture_b_acc(mac_c),
    .rd_data      (mem_rd_data),
    .acc          (mem_wr_data)
  );

endmodule

// File: tb/tb_npu_seq_engine.sv
// Scoreboard bench for npu_seq_engine: a reference model fills expected writes and done
// times; an independent monitor checks every memory write and done pulse against them.
module tb_npu_seq_engine;

  localparam int unsigned N = 4;
  localparam int unsigned K = 3;
  localparam int unsigned LAT_MM   = N * N * (3 * N + 1) + 1;
  localparam int unsigned LAT_CONV = (N - K + 1) * (3 * K + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_mm, start_conv;
  logic [63:0] base_a, base_b, base_c;
  logic        busy, done;
  logic [63:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data = 64'd0;
  logic        mem_wr_en;
  logic [63:0] mem_wr_data;

  npu_seq_engine #(.DATA_W(64), .ADDR_W(64), .N(N), .K(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_mm   (start_mm),
    .start_conv (start_conv),
    .base_a     (base_a),
    .base_b     (base_b),
    .base_c     (base_c),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] a_v [N*N];
  logic [63:0] b_v [N*N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // Memory with fixed one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= rd(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (rst_n) begin
      wr_t e;
      int unsigned d;
      check("rd_wr_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
      if (!mem_rd_en && !mem_wr_en) check("idle_addr", mem_addr, 64'd0);
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wr_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          d = exp_done.pop_front();
          check("done_latency", 64'(cyc), 64'(d));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Loads operands, queues the model's results, then pulses the start input(s).
  task automatic launch(input bit mm, input bit both,
                        input logic [63:0] ba, input logic [63:0] bb, input logic [63:0] bc);
    logic [63:0] s;
    mem.delete();
    if (mm) begin
      for (int idx = 0; idx < N * N; idx++) begin
        mem[ba + 64'(idx * 8)] = a_v[idx];
        mem[bb + 64'(idx * 8)] = b_v[idx];
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s = 64'd0;
          for (int k = 0; k < N; k++) s = s + a_v[i*N+k] * b_v[k*N+j];
          exp_wr.push_back('{addr: bc + 64'((i * N + j) * 8), data: s});
        end
    end else begin
      for (int idx = 0; idx < N; idx++) mem[ba + 64'(idx * 8)] = a_v[idx];
      for (int idx = 0; idx < K; idx++) mem[bb + 64'(idx * 8)] = b_v[idx];
      for (int i = 0; i <= N - K; i++) begin
        s = 64'd0;
        for (int k = 0; k < K; k++) s = s + a_v[i+k] * b_v[k];
        exp_wr.push_back('{addr: bc + 64'(i * 8), data: s});
      end
    end
    @(posedge clk);
    #1;
    base_a     = ba;
    base_b     = bb;
    base_c     = bc;
    start_mm   = mm | both;
    start_conv = !mm | both;
    exp_done.push_back(cyc + (mm ? LAT_MM : LAT_CONV));
    @(posedge clk);
    #1;
    start_mm   = 1'b0;
    start_conv = 1'b0;
    base_a     = {$urandom, $urandom};
    base_b     = {$urandom, $urandom};
    base_c     = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) fail_now("done_timeout");
    repeat (4) @(posedge clk);
    check("writes_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    check({tag, "_addr"}, mem_addr, 64'd0);
    check({tag, "_wr_data"}, mem_wr_data, 64'd0);
  endtask

  initial begin
    int r0;
    int w0;
    logic [63:0] rb;
    rst_n      = 1'b0;
    start_mm   = 1'b0;
    start_conv = 1'b0;
    base_a     = 64'd0;
    base_b     = 64'd0;
    base_c     = 64'd0;

    // Reset held while starts toggle.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      start_mm   = c[0];
      start_conv = c[1];
      base_a     = {$urandom, $urandom};
      @(negedge clk);
      check_quiet("reset");
    end
    start_mm   = 1'b0;
    start_conv = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity times 1..16.
    for (int idx = 0; idx < N * N; idx++) begin
      a_v[idx] = (idx / N == idx % N) ? 64'd1 : 64'd0;
      b_v[idx] = 64'(idx + 1);
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    launch(1'b1, 1'b0, 64'h1000, 64'h2000, 64'h3000);
    wait_done();
    check("mm_read_count", 64'(rd_cnt - r0), 64'(2 * N * N * N));
    check("mm_write_count", 64'(wr_cnt - w0), 64'(N * N));

    // All 2s times all 3s.
    for (int idx = 0; idx < N * N; idx++) begin
      a_v[idx] = 64'd2;
      b_v[idx] = 64'd3;
    end
    launch(1'b1, 1'b0, 64'h4000, 64'h5000, 64'h6000);
    wait_done();

    // Accumulator wrap: 2^32 * 2^32.
    for (int idx = 0; idx < N * N; idx++) begin
      a_v[idx] = 64'd0;
      b_v[idx] = 64'd0;
    end
    a_v[0] = 64'h1_0000_0000;
    b_v[0] = 64'h1_0000_0000;
    launch(1'b1, 1'b0, 64'h100, 64'h200, 64'h300);
    wait_done();

    // Convolution [1,2,3,4] with [1,0,-1].
    a_v[0] = 64'd1; a_v[1] = 64'd2; a_v[2] = 64'd3; a_v[3] = 64'd4;
    b_v[0] = 64'd1; b_v[1] = 64'd0; b_v[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    r0 = rd_cnt;
    launch(1'b0, 1'b0, 64'h7000, 64'h7100, 64'h7200);
    wait_done();
    check("conv_read_count", 64'(rd_cnt - r0), 64'(2 * K * (N - K + 1)));

    // Both starts together: matrix multiply wins.
    for (int idx = 0; idx < N * N; idx++) begin
      a_v[idx] = 64'(idx + 3);
      b_v[idx] = 64'(2 * idx + 1);
    end
    launch(1'b1, 1'b1, 64'h8000, 64'h8100, 64'h8200);
    wait_done();

    // Re-pulsed starts mid-run are ignored.
    launch(1'b1, 1'b0, 64'h9000, 64'h9100, 64'h9200);
    repeat (30) @(posedge clk);
    #1;
    start_mm   = 1'b1;
    start_conv = 1'b1;
    base_a     = 64'hDEAD_0000;
    @(posedge clk);
    #1;
    start_mm   = 1'b0;
    start_conv = 1'b0;
    wait_done();

    // Randomized operands and bases, including bases near the top of the address space.
    for (int t = 0; t < 8; t++) begin
      for (int idx = 0; idx < N * N; idx++) begin
        a_v[idx] = {$urandom, $urandom};
        b_v[idx] = {$urandom, $urandom};
      end
      rb = (t % 3 == 0) ? (64'hFFFF_FFFF_FFFF_FFC0 + 64'(8 * $urandom_range(0, 7)))
                        : {$urandom, $urandom & 32'hFFFF_FFF8};
      launch(($urandom & 1) == 1, 1'b0, rb, rb + 64'h100, rb + 64'h200);
      wait_done();
    end

    // Asynchronous reset mid matrix multiply.
    for (int idx = 0; idx < N * N; idx++) begin
      a_v[idx] = 64'(idx);
      b_v[idx] = 64'(idx + 7);
    end
    launch(1'b1, 1'b0, 64'hA000, 64'hA100, 64'hA200);
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("abort");
    exp_wr.delete();
    exp_done.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (250) @(posedge clk);

    // Fresh convolution after the abort.
    for (int idx = 0; idx < N; idx++) a_v[idx] = {$urandom, $urandom};
    for (int idx = 0; idx < K; idx++) b_v[idx] = {$urandom, $urandom};
    launch(1'b0, 1'b0, 64'hB000, 64'hB100, 64'hB200);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
